// File: rtl/regfile_pkg.sv
// Shared helpers for the parametrised register file: lane count, byte-lane merge
// and a parameter sanity check used at elaboration.
package regfile_pkg;

  localparam int MAX_W     = 256;
  localparam int MAX_LANES = MAX_W / 8;

  function automatic int lanes_of(input int width);
    return width / 8;
  endfunction

  // Callers zero-extend to MAX_W and truncate the result back to their own width.
  function automatic logic [MAX_W-1:0] merge_be(input logic [MAX_W-1:0]     old_v,
                                                input logic [MAX_W-1:0]     new_v,
                                                input logic [MAX_LANES-1:0] be);
    logic [MAX_W-1:0] r;
    r = old_v;
    for (int i = 0; i < MAX_LANES; i++)
      if (be[i]) r[8*i +: 8] = new_v[8*i +: 8];
    return r;
  endfunction

  function automatic bit cfg_ok(input int width, input int depth, input int addr_w);
    return (width > 0) && (width % 8 == 0) && (width <= MAX_W) &&
           (depth >= 2) && ((2 ** addr_w) >= depth);
  endfunction

endpackage

// File: rtl/register_file_reg_entry.sv
// One storage word: async reset, sync clear (wins over write), per-lane write enables.
module reg_entry
  import regfile_pkg::*;
#(
  parameter int               WIDTH       = 16,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       clear,
  input  logic                       we,
  input  logic [WIDTH-1:0]           d,
  input  logic [lanes_of(WIDTH)-1:0] be,
  output logic [WIDTH-1:0]           q
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)      q <= RESET_VALUE;
    else if (clear) q <= RESET_VALUE;
    else if (we)    q <= WIDTH'(merge_be(MAX_W'(q), MAX_W'(d), MAX_LANES'(be)));
  end

endmodule

// File: rtl/register_file_param.sv
// DEPTH x WIDTH register file: one byte-enabled write port, two registered
// write-first read ports, synchronous clear, optional hard-wired zero entry.
module register_file_param
  import regfile_pkg::*;
#(
  parameter int                WIDTH       = 16,
  parameter int                DEPTH       = 8,
  parameter int                ADDR_W      = 3,
  parameter int                ZERO_REG    = 0,
  parameter logic [WIDTH-1:0]  RESET_VALUE = '0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       clear,
  input  logic                       wr_en,
  input  logic [ADDR_W-1:0]          wr_addr,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic [lanes_of(WIDTH)-1:0] wr_be,
  input  logic                       rd_en_a,
  input  logic [ADDR_W-1:0]          rd_addr_a,
  output logic [WIDTH-1:0]           rd_data_a,
  output logic                       rd_valid_a,
  input  logic                       rd_en_b,
  input  logic [ADDR_W-1:0]          rd_addr_b,
  output logic [WIDTH-1:0]           rd_data_b,
  output logic                       rd_valid_b
);

  localparam int NPORT = 2;

  if (!cfg_ok(WIDTH, DEPTH, ADDR_W)) begin : g_bad_cfg
    $error("register_file_param: WIDTH must be a multiple of 8 and 2**ADDR_W >= DEPTH >= 2");
  end

  logic [DEPTH-1:0][WIDTH-1:0] q;

  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    if (ZERO_REG != 0 && i == 0) begin : g_zero
      assign q[i] = '0;
    end else begin : g_reg
      reg_entry #(.WIDTH(WIDTH), .RESET_VALUE(RESET_VALUE)) u_entry (
        .clk   (clk),
        .reset (reset),
        .clear (clear),
        .we    (wr_en && (wr_addr == ADDR_W'(i))),
        .d     (wr_data),
        .be    (wr_be),
        .q     (q[i])
      );
    end
  end

  logic [NPORT-1:0]             rd_en;
  logic [NPORT-1:0][ADDR_W-1:0] rd_addr;
  logic [NPORT-1:0][WIDTH-1:0]  rd_next, rd_q;
  logic [NPORT-1:0]             vld_pipe;

  assign rd_en   = {rd_en_b, rd_en_a};
  assign rd_addr = {rd_addr_b, rd_addr_a};

  // Out-of-range and zero-entry addresses never match, so they fall through to 0.
  always_comb begin
    for (int p = 0; p < NPORT; p++) begin
      rd_next[p] = '0;
      for (int i = 0; i < DEPTH; i++) begin
        if (rd_addr[p] == ADDR_W'(i) && !(ZERO_REG != 0 && i == 0)) begin
          if (clear)
            rd_next[p] = RESET_VALUE;
          else if (wr_en && wr_addr == rd_addr[p])
            rd_next[p] = WIDTH'(merge_be(MAX_W'(q[i]), MAX_W'(wr_data), MAX_LANES'(wr_be)));
          else
            rd_next[p] = q[i];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_q     <= '0;
      vld_pipe <= '0;
    end else begin
      vld_pipe <= rd_en;
      for (int p = 0; p < NPORT; p++)
        if (rd_en[p]) rd_q[p] <= rd_next[p];
    end
  end

  assign rd_data_a  = rd_q[0];
  assign rd_data_b  = rd_q[1];
  assign rd_valid_a = vld_pipe[0];
  assign rd_valid_b = vld_pipe[1];

endmodule

// File: tb/tb_register_file_param.sv
// Bench for register_file_param: two instances (plain 8-entry, and 6-entry with a
// zero register and nonzero reset value) driven in lockstep against an array model.
module tb_register_file_param;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        clear = 1'b0;
  logic        wr_en = 1'b0;
  logic [2:0]  wr_addr = '0;
  logic [15:0] wr_data = '0;
  logic [1:0]  wr_be = '0;
  logic        rd_en_a = 1'b0, rd_en_b = 1'b0;
  logic [2:0]  rd_addr_a = '0, rd_addr_b = '0;

  logic [15:0] rd_data_a0, rd_data_b0, rd_data_a1, rd_data_b1;
  logic        rd_valid_a0, rd_valid_b0, rd_valid_a1, rd_valid_b1;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  register_file_param #(.WIDTH(16), .DEPTH(8), .ADDR_W(3), .ZERO_REG(0), .RESET_VALUE(16'h0000)) dut0 (
    .clk(clk), .reset(reset), .clear(clear), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_be(wr_be),
    .rd_en_a(rd_en_a), .rd_addr_a(rd_addr_a), .rd_data_a(rd_data_a0), .rd_valid_a(rd_valid_a0),
    .rd_en_b(rd_en_b), .rd_addr_b(rd_addr_b), .rd_data_b(rd_data_b0), .rd_valid_b(rd_valid_b0)
  );

  register_file_param #(.WIDTH(16), .DEPTH(6), .ADDR_W(3), .ZERO_REG(1), .RESET_VALUE(16'h0F0F)) dut1 (
    .clk(clk), .reset(reset), .clear(clear), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_be(wr_be),
    .rd_en_a(rd_en_a), .rd_addr_a(rd_addr_a), .rd_data_a(rd_data_a1), .rd_valid_a(rd_valid_a1),
    .rd_en_b(rd_en_b), .rd_addr_b(rd_addr_b), .rd_data_b(rd_data_b1), .rd_valid_b(rd_valid_b1)
  );

  // ---------------- model: k=0 -> dut0, k=1 -> dut1 ----------------
  typedef logic [15:0] mem_t [8];

  mem_t        mm [2];
  logic [15:0] md [2][2];
  logic        mv [2][2];

  function automatic int dep(int k);
    return (k == 1) ? 6 : 8;
  endfunction

  function automatic logic [15:0] rv(int k);
    return (k == 1) ? 16'h0F0F : 16'h0000;
  endfunction

  function automatic bit usable(int k, logic [2:0] a);
    return (int'(a) < dep(k)) && !(k == 1 && a == 3'd0);
  endfunction

  function automatic mem_t next_mem(int k, mem_t cur);
    mem_t m;
    m = cur;
    if (clear) begin
      for (int i = 0; i < 8; i++) m[i] = rv(k);
    end else if (wr_en && usable(k, wr_addr)) begin
      if (wr_be[0]) m[wr_addr][7:0]  = wr_data[7:0];
      if (wr_be[1]) m[wr_addr][15:8] = wr_data[15:8];
    end
    return m;
  endfunction

  function automatic logic [15:0] mread(int k, mem_t m, logic [2:0] a);
    return usable(k, a) ? m[a] : 16'h0000;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < 2; k++) begin
        for (int i = 0; i < 8; i++) mm[k][i] <= rv(k);
        for (int p = 0; p < 2; p++) begin
          md[k][p] <= 16'h0000;
          mv[k][p] <= 1'b0;
        end
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        mm[k] <= next_mem(k, mm[k]);
        mv[k][0] <= rd_en_a;
        mv[k][1] <= rd_en_b;
        if (rd_en_a) md[k][0] <= mread(k, next_mem(k, mm[k]), rd_addr_a);
        if (rd_en_b) md[k][1] <= mread(k, next_mem(k, mm[k]), rd_addr_b);
      end
    end
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // every-cycle comparison against the model
  always @(negedge clk) begin
    if ($time > 2) begin
      check("cmp_data_a0", rd_data_a0, md[0][0]);
      check("cmp_data_b0", rd_data_b0, md[0][1]);
      check("cmp_data_a1", rd_data_a1, md[1][0]);
      check("cmp_data_b1", rd_data_b1, md[1][1]);
      check("cmp_vld_a0", 16'(rd_valid_a0), 16'(mv[0][0]));
      check("cmp_vld_b0", 16'(rd_valid_b0), 16'(mv[0][1]));
      check("cmp_vld_a1", 16'(rd_valid_a1), 16'(mv[1][0]));
      check("cmp_vld_b1", 16'(rd_valid_b1), 16'(mv[1][1]));
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en = 1'b0; rd_en_a = 1'b0; rd_en_b = 1'b0; clear = 1'b0;
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] d, input logic [1:0] be);
    wr_en = 1'b1; wr_addr = a; wr_data = d; wr_be = be;
    cyc();
    wr_en = 1'b0;
  endtask

  task automatic rd_a(input logic [2:0] a);
    rd_en_a = 1'b1; rd_addr_a = a;
    cyc();
    rd_en_a = 1'b0;
  endtask

  initial begin
    #1 reset = 1'b1;
    repeat (3) cyc();
    reset = 1'b0;
    cyc();

    // async reset mid-cycle clears outputs immediately
    wr(3'd4, 16'hBEEF, 2'b11);
    rd_en_a = 1'b1; rd_addr_a = 3'd4;
    cyc();
    check("pre_reset_data", rd_data_a0, 16'hBEEF);
    check("pre_reset_vld", 16'(rd_valid_a0), 16'h1);
    #3 reset = 1'b1;
    #1;
    check("reset_data_a0", rd_data_a0, 16'h0000);
    check("reset_vld_a0", 16'(rd_valid_a0), 16'h0);
    check("reset_data_a1", rd_data_a1, 16'h0000);
    rd_en_a = 1'b0;
    cyc(); cyc();
    #1 reset = 1'b0;
    cyc();

    // all entries back to reset value, including the one written before reset
    for (int a = 0; a < 8; a++) begin
      rd_a(3'(a));
      check("rst_read_dut0", rd_data_a0, 16'h0000);
      check("rst_read_dut1", rd_data_a1, (a >= 1 && a <= 5) ? 16'h0F0F : 16'h0000);
      check("rst_read_vld", 16'(rd_valid_a0), 16'h1);
    end
    cyc();
    check("vld_drops", 16'(rd_valid_a0), 16'h0);

    // byte enables
    wr(3'd3, 16'hABCD, 2'b11);
    wr(3'd3, 16'h1200, 2'b10);
    rd_a(3'd3);
    check("be_merge_dut0", rd_data_a0, 16'h12CD);
    check("be_merge_dut1", rd_data_a1, 16'h12CD);

    // write-first bypass on both ports
    wr(3'd5, 16'h1111, 2'b11);
    wr_en = 1'b1; wr_addr = 3'd5; wr_data = 16'h2222; wr_be = 2'b01;
    rd_en_a = 1'b1; rd_addr_a = 3'd5; rd_en_b = 1'b1; rd_addr_b = 3'd5;
    cyc();
    idle();
    check("bypass_a0", rd_data_a0, 16'h1122);
    check("bypass_b0", rd_data_b0, 16'h1122);
    check("bypass_b1", rd_data_b1, 16'h1122);
    check("bypass_vld_b", 16'(rd_valid_b0), 16'h1);

    // zero register and out-of-range address
    wr(3'd0, 16'hFFFF, 2'b11);
    rd_a(3'd0);
    check("zero_reg_dut1", rd_data_a1, 16'h0000);
    check("entry0_dut0", rd_data_a0, 16'hFFFF);
    wr(3'd7, 16'hABAB, 2'b11);
    rd_a(3'd7);
    check("oob_dut1", rd_data_a1, 16'h0000);
    check("oob_vld_dut1", 16'(rd_valid_a1), 16'h1);
    check("entry7_dut0", rd_data_a0, 16'hABAB);
    for (int a = 0; a < 6; a++) rd_a(3'(a));
    rd_a(3'd5);
    check("entry5_kept", rd_data_a1, 16'h1122);

    // clear beats a simultaneous write; read returns reset value
    for (int a = 0; a < 8; a++) wr(3'(a), 16'h5A5A, 2'b11);
    clear = 1'b1; wr_en = 1'b1; wr_addr = 3'd2; wr_data = 16'h7777; wr_be = 2'b11;
    rd_en_a = 1'b1; rd_addr_a = 3'd2; rd_en_b = 1'b1; rd_addr_b = 3'd0;
    cyc();
    check("clr_read_dut0", rd_data_a0, 16'h0000);
    check("clr_read_dut1", rd_data_a1, 16'h0F0F);
    check("clr_read_zero", rd_data_b1, 16'h0000);
    wr_addr = 3'd1; rd_en_a = 1'b0; rd_en_b = 1'b0;
    cyc();
    idle();
    rd_a(3'd2);
    check("post_clr_dut0", rd_data_a0, 16'h0000);
    check("post_clr_dut1", rd_data_a1, 16'h0F0F);
    rd_a(3'd1);
    check("held_clr_dut1", rd_data_a1, 16'h0F0F);

    // read data holds while rd_en is low
    wr(3'd1, 16'h00AA, 2'b11);
    rd_a(3'd1);
    check("hold_first", rd_data_a0, 16'h00AA);
    wr(3'd1, 16'h00BB, 2'b11);
    check("hold_1", rd_data_a0, 16'h00AA);
    check("hold_vld", 16'(rd_valid_a0), 16'h0);
    cyc(); cyc();
    check("hold_3", rd_data_a0, 16'h00AA);
    rd_a(3'd1);
    check("hold_new", rd_data_a0, 16'h00BB);

    // mixed traffic checked by the model only
    for (int n = 0; n < 60; n++) begin
      wr_en     = 1'($urandom_range(0, 1));
      wr_addr   = 3'($urandom_range(0, 7));
      wr_data   = 16'($urandom);
      wr_be     = 2'($urandom_range(0, 3));
      rd_en_a   = 1'($urandom_range(0, 1));
      rd_addr_a = 3'($urandom_range(0, 7));
      rd_en_b   = 1'($urandom_range(0, 1));
      rd_addr_b = (n % 3 == 0) ? wr_addr : 3'($urandom_range(0, 7));
      clear     = ($urandom_range(0, 15) == 0);
      cyc();
    end
    idle();
    cyc(); cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
